// File: rtl/mmu_pkg.sv
// MMU shared types: TLB entry layout, TLB write-sequencer state encoding and
// replacement LFSR polynomial.
package mmu_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  asid;
    logic [19:0] vpn;
    logic [19:0] ppn;
    logic [3:0]  perm;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SW_WR,
    ST_HW_SEL,
    ST_HW_WR,
    ST_FLUSH,
    ST_ACK
  } tlb_ctrl_state_t;

  localparam logic [15:0] TLB_LFSR_POLY = 16'hB400;

endpackage

// File: rtl/tlb_lfsr16.sv
// 16-bit Galois LFSR for TLB replacement-way selection; advances every cycle.
// A nonzero seed guarantees the register never holds zero.
module tlb_lfsr16
  import mmu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ TLB_LFSR_POLY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/tlb_update_ctrl.sv
// TLB RAM write sequencer: arbitrates flush > software write > hardware fill
// onto the single write port. Hardware-fill path present only with TLB_HW_FILL_EN.
module tlb_update_ctrl
  import mmu_pkg::*;
#(
  parameter int          TLB_ASSOC   = 4,
  parameter int          TLB_ENTRIES = 1024,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_req,
  input  tlb_entry_t           sw_entry,
  input  logic [15:0]          sw_entry_no,
  input  logic [7:0]           sw_way,
  input  logic [63:0]          lock_map,
  input  logic                 hw_req,
  input  tlb_entry_t           hw_entry,
  input  logic [15:0]          hw_entry_no,
  output logic                 hw_ack,
  output logic [7:0]           hw_way,
  output logic                 sw_ack,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 busy,
  output logic                 wr_en,
  output logic [TLB_ASSOC-1:0] wr_way,
  output logic [IDX_W-1:0]     wr_adr,
  output tlb_entry_t           wr_dat
);

  localparam int WAY_W = $clog2(TLB_ASSOC);

  tlb_ctrl_state_t      state_q, state_d;
  logic                 wr_en_q, wr_en_d;
  logic [TLB_ASSOC-1:0] wr_way_q, wr_way_d;
  logic [IDX_W-1:0]     wr_adr_q, wr_adr_d;
  tlb_entry_t           wr_dat_q, wr_dat_d;
  logic                 sw_ack_q, sw_ack_d;
  logic                 flush_done_q, flush_done_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 hw_ack_d;
  logic [7:0]           hw_way_d;
  logic [WAY_W-1:0]     sel_way;

  function automatic logic [TLB_ASSOC-1:0] way_mask(input logic [7:0] w);
    logic [TLB_ASSOC-1:0] m;
    m = '0;
    if (w >= 8'(TLB_ASSOC)) m[TLB_ASSOC-1] = 1'b1;
    else                    m[w[WAY_W-1:0]] = 1'b1;
    return m;
  endfunction

`ifdef TLB_HW_FILL_EN
  logic       hw_ack_q;
  logic [7:0] hw_way_q;
  logic [15:0] lfsr;
  logic [5:0]  grp;
  logic        unused_ok;

  tlb_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  // wr_adr_q already holds the latched fill index while in HW_SEL
  assign grp = wr_adr_q[IDX_W-1 -: 6];

  always_comb begin
    sel_way = lfsr[WAY_W-1:0];
    if (lock_map[grp] && sel_way == WAY_W'(TLB_ASSOC-1)) sel_way = WAY_W'(TLB_ASSOC-2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_ack_q <= 1'b0;
      hw_way_q <= '0;
    end else begin
      hw_ack_q <= hw_ack_d;
      hw_way_q <= hw_way_d;
    end
  end

  assign hw_ack    = hw_ack_q;
  assign hw_way    = hw_way_q;
  assign unused_ok = ^{sw_entry_no, hw_entry_no, lfsr};
`else
  logic unused_ok;
  assign sel_way   = '0;
  assign hw_ack    = 1'b0;
  assign hw_way    = '0;
  assign unused_ok = ^{sw_entry_no, hw_req, hw_entry, hw_entry_no, lock_map, sel_way,
                       hw_ack_d, hw_way_d};
`endif

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_way_d     = wr_way_q;
    wr_adr_d     = wr_adr_q;
    wr_dat_d     = wr_dat_q;
    sw_ack_d     = 1'b0;
    hw_ack_d     = 1'b0;
    hw_way_d     = hw_way;
    flush_done_d = 1'b0;
    cnt_d        = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d  = ST_FLUSH;
          wr_en_d  = 1'b1;
          wr_way_d = '1;
          wr_adr_d = '0;
          wr_dat_d = '0;
          cnt_d    = '0;
        end else if (sw_req) begin
          state_d  = ST_SW_WR;
          wr_en_d  = 1'b1;
          wr_way_d = way_mask(sw_way);
          wr_adr_d = sw_entry_no[IDX_W-1:0];
          wr_dat_d = sw_entry;
        end
`ifdef TLB_HW_FILL_EN
        else if (hw_req) begin
          state_d  = ST_HW_SEL;
          wr_adr_d = hw_entry_no[IDX_W-1:0];
          wr_dat_d = hw_entry;
        end
`endif
      end
      ST_SW_WR: begin
        state_d  = ST_ACK;
        sw_ack_d = 1'b1;
      end
`ifdef TLB_HW_FILL_EN
      ST_HW_SEL: begin
        state_d  = ST_HW_WR;
        wr_en_d  = 1'b1;
        wr_way_d = way_mask(8'(sel_way));
        hw_way_d = 8'(sel_way);
      end
      ST_HW_WR: begin
        state_d  = ST_ACK;
        hw_ack_d = 1'b1;
      end
`endif
      ST_FLUSH: begin
        if (cnt_q == IDX_W'(TLB_ENTRIES-1)) begin
          state_d      = ST_ACK;
          flush_done_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          wr_en_d  = 1'b1;
          wr_adr_d = cnt_q + 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_en_q      <= 1'b0;
      wr_way_q     <= '0;
      wr_adr_q     <= '0;
      wr_dat_q     <= '0;
      sw_ack_q     <= 1'b0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_way_q     <= wr_way_d;
      wr_adr_q     <= wr_adr_d;
      wr_dat_q     <= wr_dat_d;
      sw_ack_q     <= sw_ack_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_way     = wr_way_q;
  assign wr_adr     = wr_adr_q;
  assign wr_dat     = wr_dat_q;
  assign sw_ack     = sw_ack_q;
  assign flush_done = flush_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tlb_update_ctrl.sv
// Self-checking bench for tlb_update_ctrl: cycle-scheduled expectation model
// plus directed tests with literal expectations.
module tb_tlb_update_ctrl;
  import mmu_pkg::*;

  localparam int          ASSOC   = 4;
  localparam int          ENTRIES = 1024;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_req = 1'b0, hw_req = 1'b0, flush_req = 1'b0;
  tlb_entry_t  sw_entry = '0, hw_entry = '0;
  logic [15:0] sw_entry_no = '0, hw_entry_no = '0;
  logic [7:0]  sw_way = '0;
  logic [63:0] lock_map = '0;
  logic        hw_ack, sw_ack, flush_done, busy, wr_en;
  logic [7:0]  hw_way;
  logic [3:0]  wr_way;
  logic [9:0]  wr_adr;
  tlb_entry_t  wr_dat;

  tlb_update_ctrl #(.TLB_ASSOC(ASSOC), .TLB_ENTRIES(ENTRIES), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_entry(sw_entry), .sw_entry_no(sw_entry_no),
    .sw_way(sw_way), .lock_map(lock_map), .hw_req(hw_req), .hw_entry(hw_entry),
    .hw_entry_no(hw_entry_no), .hw_ack(hw_ack), .hw_way(hw_way), .sw_ack(sw_ack),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy), .wr_en(wr_en),
    .wr_way(wr_way), .wr_adr(wr_adr), .wr_dat(wr_dat)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] mask(input int w);
    if (w >= ASSOC) return 4'b1000;
    return 4'(1 << w);
  endfunction

  function automatic tlb_entry_t mk(input int k);
    tlb_entry_t e;
    e.valid = 1'b1;
    e.asid  = 8'(k * 17);
    e.vpn   = 20'(k * 3001 + 1);
    e.ppn   = 20'(k * 7919 + 5);
    e.perm  = 4'(k);
    return e;
  endfunction

  // Expected outputs per cycle; cycles absent from the schedule expect an idle port.
  typedef struct {
    bit         busy, wr_en, sw_ack, hw_ack, fd;
    logic [3:0] way;
    logic [9:0] adr;
    tlb_entry_t dat;
    logic [7:0] hw_way;
  } exp_t;

  function automatic exp_t blank();
    exp_t e;
    e.busy = 0; e.wr_en = 0; e.sw_ack = 0; e.hw_ack = 0; e.fd = 0;
    e.way = '0; e.adr = '0; e.dat = '0; e.hw_way = '0;
    return e;
  endfunction

  exp_t        sched[int];
  exp_t        e, ne;
  int          free_at = 0, hw_sel_at = -1;
  logic [9:0]  hw_adr_m;
  tlb_entry_t  hw_dat_m;
  logic [15:0] m_lfsr = SEED;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", 64'(busy), 0);
      check("rst_wr_en", 64'(wr_en), 0);
      check("rst_wr_way", 64'(wr_way), 0);
      check("rst_wr_adr", 64'(wr_adr), 0);
      check("rst_wr_dat", 64'(wr_dat), 0);
      check("rst_acks", 64'({sw_ack, hw_ack, flush_done}), 0);
      check("rst_hw_way", 64'(hw_way), 0);
      sched.delete();
      free_at   = cyc + 1;
      hw_sel_at = -1;
      m_lfsr    = SEED;
    end else begin
      if (sched.exists(cyc)) begin
        e = sched[cyc];
        sched.delete(cyc);
      end else e = blank();
      check("busy", 64'(busy), 64'(e.busy));
      check("wr_en", 64'(wr_en), 64'(e.wr_en));
      check("sw_ack", 64'(sw_ack), 64'(e.sw_ack));
      check("hw_ack", 64'(hw_ack), 64'(e.hw_ack));
      check("flush_done", 64'(flush_done), 64'(e.fd));
      if (e.wr_en) begin
        check("wr_way", 64'(wr_way), 64'(e.way));
        check("wr_adr", 64'(wr_adr), 64'(e.adr));
        check("wr_dat", 64'(wr_dat), 64'(e.dat));
      end
`ifdef TLB_HW_FILL_EN
      if (e.hw_ack) check("hw_way", 64'(hw_way), 64'(e.hw_way));
      if (cyc == hw_sel_at) begin
        int w;
        w = int'(m_lfsr % ASSOC);
        if (lock_map[hw_adr_m / (ENTRIES / 64)] && w == ASSOC - 1) w = ASSOC - 2;
        ne = blank(); ne.busy = 1; ne.wr_en = 1; ne.way = mask(w); ne.adr = hw_adr_m;
        ne.dat = hw_dat_m; sched[cyc + 1] = ne;
        ne = blank(); ne.busy = 1; ne.hw_ack = 1; ne.hw_way = 8'(w); sched[cyc + 2] = ne;
      end
`else
      check("hw_way_tied", 64'(hw_way), 0);
`endif
      if (cyc >= free_at) begin
        if (flush_req) begin
          for (int k = 1; k <= ENTRIES; k++) begin
            ne = blank(); ne.busy = 1; ne.wr_en = 1; ne.way = 4'hF; ne.adr = 10'(k - 1);
            sched[cyc + k] = ne;
          end
          ne = blank(); ne.busy = 1; ne.fd = 1; sched[cyc + ENTRIES + 1] = ne;
          free_at = cyc + ENTRIES + 2;
        end else if (sw_req) begin
          ne = blank(); ne.busy = 1; ne.wr_en = 1; ne.way = mask(int'(sw_way));
          ne.adr = sw_entry_no[9:0]; ne.dat = sw_entry; sched[cyc + 1] = ne;
          ne = blank(); ne.busy = 1; ne.sw_ack = 1; sched[cyc + 2] = ne;
          free_at = cyc + 3;
        end
`ifdef TLB_HW_FILL_EN
        else if (hw_req) begin
          ne = blank(); ne.busy = 1; sched[cyc + 1] = ne;
          hw_sel_at = cyc + 1;
          hw_adr_m  = hw_entry_no[9:0];
          hw_dat_m  = hw_entry;
          free_at   = cyc + 4;
        end
`endif
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    cyc++;
  end

  // kind: 0 sw_ack, 1 hw_ack, 2 flush_done; lat = negedges after call, -1 on timeout
  task automatic wait_ack(input int kind, input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((kind == 0 && sw_ack) || (kind == 1 && hw_ack) || (kind == 2 && flush_done)) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_wr(input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wr_en) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_sw(input logic [15:0] no, input logic [7:0] w, input int k);
    int lat;
    @(posedge clk); #2;
    sw_entry_no = no; sw_way = w; sw_entry = mk(k); sw_req = 1'b1;
    wait_ack(0, 20, lat);
    check("sw_ack_lat", 64'(lat), 2);
    @(posedge clk); #2;
    sw_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwr, bad, dn, lf, ls, lh;
    repeat (3) @(negedge clk);
    check("reset_busy_lit", 64'(busy), 0);
    check("reset_wr_en_lit", 64'(wr_en), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // software write: set 5, way 2
    @(posedge clk); #2;
    sw_entry_no = 16'h0005; sw_way = 8'd2; sw_entry = mk(1); sw_req = 1'b1;
    wait_wr(10, lat);
    check("sw_wr_lat_lit", 64'(lat), 1);
    check("sw_adr_lit", 64'(wr_adr), 64'd5);
    check("sw_way_lit", 64'(wr_way), 64'b0100);
    wait_ack(0, 10, lat);
    check("sw_ack_next_lit", 64'(lat), 0);
    @(posedge clk); #2;
    sw_req = 1'b0;

    // out-of-range way clamps to the last way; high index bits ignored
    @(posedge clk); #2;
    sw_entry_no = 16'hFC3A; sw_way = 8'd9; sw_entry = mk(2); sw_req = 1'b1;
    wait_wr(10, lat);
    check("sw_clamp_way_lit", 64'(wr_way), 64'b1000);
    check("sw_trunc_adr_lit", 64'(wr_adr), 64'h03A);
    wait_ack(0, 10, lat);
    @(posedge clk); #2;
    sw_req = 1'b0;

`ifdef TLB_HW_FILL_EN
    for (int pass = 0; pass < 2; pass++) begin
      logic [15:0] nx;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #2;
        nx = lfsr_next(m_lfsr);
        if (nx[1:0] == 2'd3) break;
      end
      lock_map = '0;
      lock_map[63] = (pass == 0);
      hw_entry_no = 16'h03F0; hw_entry = mk(7 + pass); hw_req = 1'b1;
      wait_wr(10, lat);
      check("hw_wr_lat_lit", 64'(lat), 2);
      check("hw_adr_lit", 64'(wr_adr), 64'h3F0);
      check("hw_wr_way_lit", 64'(wr_way), (pass == 0) ? 64'b0100 : 64'b1000);
      wait_ack(1, 10, lat);
      check("hw_ack_next_lit", 64'(lat), 0);
      check("hw_way_lit", 64'(hw_way), (pass == 0) ? 64'd2 : 64'd3);
      @(posedge clk); #2;
      hw_req = 1'b0;
    end
    lock_map = 64'hFFFF_0000_FFFF_0000;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      hw_entry_no = 16'(k * 171 + 40); hw_entry = mk(20 + k); hw_req = 1'b1;
      wait_ack(1, 10, lat);
      check("hw_fill_ack_lat", 64'(lat), 3);
      @(posedge clk); #2;
      hw_req = 1'b0;
    end
`endif

    // full flush
    @(posedge clk); #2;
    flush_req = 1'b1;
    nwr = 0; bad = 0; dn = -1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (wr_en) begin
        if (wr_adr !== 10'(nwr)) bad++;
        nwr++;
      end
      if (flush_done) begin
        dn = i;
        break;
      end
    end
    check("flush_order_errs", 64'(bad), 0);
    check("flush_wr_count", 64'(nwr), 1024);
    check("flush_done_cycle", 64'(dn), 1025);
    @(posedge clk); #2;
    flush_req = 1'b0;

    // simultaneous requests: flush, then sw, then hw
    @(posedge clk); #2;
    flush_req = 1'b1;
    sw_req = 1'b1; sw_entry_no = 16'h0123; sw_way = 8'd1; sw_entry = mk(3);
    hw_req = 1'b1; hw_entry_no = 16'h0200; hw_entry = mk(4); lock_map = '0;
    lf = -1; ls = -1; lh = -1;
    fork
      begin
        wait_ack(2, 1100, lf);
        @(posedge clk); #2;
        flush_req = 1'b0;
      end
      begin
        wait_ack(0, 1200, ls);
        @(posedge clk); #2;
        sw_req = 1'b0;
      end
`ifdef TLB_HW_FILL_EN
      begin
        wait_ack(1, 1300, lh);
        @(posedge clk); #2;
        hw_req = 1'b0;
      end
`endif
    join
    check("prio_flush_lat", 64'(lf), 1025);
    check("prio_sw_lat", 64'(ls), 1028);
`ifdef TLB_HW_FILL_EN
    check("prio_hw_lat", 64'(lh), 1032);
`else
    // hw_req still held: must be ignored entirely
    nwr = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en) nwr++;
      if (hw_ack) bad++;
    end
    check("nohw_wr_en_count", 64'(nwr), 0);
    check("nohw_hw_ack_count", 64'(bad), 0);
    check("nohw_busy", 64'(busy), 0);
    @(posedge clk); #2;
    hw_req = 1'b0;
`endif

    // reset during flush at index 100
    @(posedge clk); #2;
    flush_req = 1'b1;
    dn = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_en && wr_adr == 10'd100) begin
        dn = 1;
        break;
      end
    end
    check("flush_reached_100", 64'(dn), 1);
    #1;
    rst = 1'b1;
    flush_req = 1'b0;
    #1;
    check("abort_wr_en_lit", 64'(wr_en), 0);
    check("abort_busy_lit", 64'(busy), 0);
    check("abort_no_done_lit", 64'(flush_done), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    do_sw(16'h0077, 8'd3, 5);
    do_sw(16'h03FF, 8'd0, 6);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlb_update_ctrl.md
# tlb_update_ctrl

Write sequencer for the set-associative TLB RAM. It arbitrates between three sources: software entry writes committed through the TLB bus interface hold registers, hardware miss-fills from the page-table walker, and a whole-TLB flush. It selects a replacement way for hardware fills while honouring the lock map, and drives the single RAM write port.

## Interface
- TLB_ASSOC, 4, ways per set; power of two, 2..8
- TLB_ENTRIES, 1024, sets per way; power of two; IDX_W = $clog2(TLB_ENTRIES)
- LFSR_SEED, 16'hACE1, replacement LFSR reset value; must be nonzero
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- sw_req  in  1  software write request; level, held until sw_ack
- sw_entry  in  tlb_entry_t  entry to write
- sw_entry_no  in  16  set index; bits above IDX_W ignored
- sw_way  in  8  target way; values >= TLB_ASSOC are written to way TLB_ASSOC-1
- lock_map  in  64  group lock bits, one bit per 1/64 of the set range
- hw_req  in  1  walker fill request; level, held until hw_ack
- hw_entry  in  tlb_entry_t  entry to fill
- hw_entry_no  in  16  set index
- hw_ack  out  1  one-cycle fill-complete pulse
- hw_way  out  8  way chosen; valid with hw_ack
- sw_ack  out  1  one-cycle write-complete pulse
- flush_req  in  1  invalidate-all request; level
- flush_done  out  1  one-cycle pulse
- busy  out  1  state != IDLE
- wr_en  out  1  RAM write strobe
- wr_way  out  TLB_ASSOC  one-hot write-way mask (all ones during flush)
- wr_adr  out  IDX_W  RAM set index
- wr_dat  out  tlb_entry_t  RAM write data

## Operation
- States: IDLE, SW_WR, HW_SEL, HW_WR, FLUSH, ACK.
- IDLE grant priority: flush_req > sw_req > hw_req. The request fields are latched on the grant.
- SW_WR: drive a write to the latched set and way. Next state is ACK, which pulses sw_ack.
- HW_SEL: candidate way = lfsr[log2(TLB_ASSOC)-1:0]. The group index is entry_no[IDX_W-1:IDX_W-6].
  - If lock_map[group] is set and the candidate is TLB_ASSOC-1, use TLB_ASSOC-2.
  - The way register is loaded, then the state moves to HW_WR.
- HW_WR: drive the write. Next state is ACK, which pulses hw_ack with hw_way.
- FLUSH: a counter runs from 0 to TLB_ENTRIES-1. Each cycle writes wr_dat=0 with wr_way all ones.
  - After the last index, go to ACK, which pulses flush_done.
  - The lock map does not protect entries from flush.
- ACK: pulse the ack for the completed operation, then return to IDLE.
  - A requester must drop its req in the ack cycle, or it is granted again.
- LFSR: 16-bit Galois, polynomial TLB_LFSR_POLY. It advances every cycle and never holds zero.
- lock_map is sampled live in HW_SEL. Changes in other states have no effect on an operation already in flight.

## Timing
- Reset values: state IDLE, all acks 0, busy 0, wr_en 0, wr_way 0, wr_adr 0, wr_dat 0, hw_way 0, flush counter 0, lfsr LFSR_SEED.
- Software write, grant in cycle N: wr_en at N+1, sw_ack at N+2. Three cycles per write.
- Hardware fill, grant in cycle N: way selected at N+1, wr_en at N+2, hw_ack at N+3.
- Flush, grant in cycle N: wr_en at N+1 .. N+TLB_ENTRIES, flush_done at N+TLB_ENTRIES+1.
- Simultaneous requests: only the highest-priority one is granted. The others wait and are not lost, because requests are levels.
- A request that rises while busy is granted in the first IDLE cycle.
- All outputs are registered. wr_en is never asserted in IDLE or ACK.
- Reset asserted mid-operation aborts it immediately. No ack is issued, and a partial flush leaves the RAM partially cleared.

## Configuration
- TLB_HW_FILL_EN defined: hardware-fill path, HW_SEL/HW_WR states and LFSR are present.
- TLB_HW_FILL_EN undefined:
  - hw_req is ignored; hw_ack and hw_way are tied to 0.
  - The LFSR and both HW states are removed.
  - Software writes and flush behave identically.

## Structure
- mmu_pkg additions: tlb_ctrl_state_t enum and TLB_LFSR_POLY (16'hB400). tlb_entry_t is already there.
- One sub-module, tlb_lfsr16 (clk, rst, seed, q): the replacement LFSR, instantiated only under TLB_HW_FILL_EN.

## Test plan
- sw_req with sw_entry_no=5, sw_way=2 → wr_en one cycle later with wr_adr=5, wr_way=4'b0100; sw_ack the following cycle.
- Force the LFSR candidate to 3, lock_map[63]=1, hw_entry_no=0x3F0 (group 63) → wr_way=4'b0100 and hw_way=2. With lock_map[63]=0 → way 3.
- flush_req with TLB_ENTRIES=1024 → exactly 1024 wr_en cycles, wr_dat=0, wr_way=4'hF, addresses 0..1023 in order; flush_done at cycle 1025.
- sw_req, hw_req and flush_req asserted in the same cycle → order is flush, then sw, then hw, each with its own ack.
- Reset asserted at flush index 100 → wr_en=0 and state IDLE immediately, no flush_done; the next sw write completes normally.
- Build without TLB_HW_FILL_EN, hw_req held for 20 cycles → no wr_en, hw_ack stays 0.
